// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock engine.
//   - state_e     : framing FSM states (IDLE/LEAD/RUN/LAG)
//   - CPOL_*/CPHA_*: clock polarity / phase encodings as seen on i_cpol/i_cpha
//   - DEF_DIV_W/DEF_CNT_W: default divider and bit-count widths
package spi_pkg;

  localparam int unsigned DEF_DIV_W = 16;
  localparam int unsigned DEF_CNT_W = 6;

  localparam logic CPOL_IDLE_LOW  = 1'b0;
  localparam logic CPOL_IDLE_HIGH = 1'b1;
  localparam logic CPHA_LEADING   = 1'b0;
  localparam logic CPHA_TRAILING  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_RUN,
    ST_LAG
  } state_e;

endpackage

// File: rtl/spi_half_period_tick.sv
// Half-period timebase for the SPI engine.
// Ports:
//   i_clk, i_rst : system clock, asynchronous active-high reset
//   i_run        : engine is framing a transfer
//   i_div        : half-period minus one (D = i_div + 1 cycles)
//   o_tick       : one-cycle pulse every D cycles while i_run is high
// While not running the counter sits preloaded with i_div, so the first tick
// lands exactly D cycles after i_run rises.
module spi_half_period_tick
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = i_run && (cnt_q == '0);
    cnt_d  = cnt_q - ONE;
    if (!i_run || o_tick) begin
      cnt_d = i_div;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock and framing engine.
// Generates SCLK in all four CPOL/CPHA modes from a programmable divider,
// frames the transfer with chip select plus lead/lag guard time, and emits
// single-cycle sample/shift strobes for the data shifter.
// Ports:
//   i_clk, i_rst       : system clock, asynchronous active-high reset
//   i_enable           : block enable; low aborts an active transfer
//   i_start            : transfer request, only looked at in IDLE
//   i_cpol, i_cpha     : SPI mode, latched at acceptance
//   i_divider          : half-period minus one, latched at acceptance
//   i_nbits            : bits per transfer minus one, latched at acceptance
//   o_sclk, o_cs_n     : serial clock and active-low chip select
//   o_sample, o_shift  : capture-MISO / advance-MOSI strobes
//   o_busy, o_done     : transfer active / normal-completion pulse
// All outputs are registered.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [DIV_W-1:0] i_divider,
  input  logic [CNT_W-1:0] i_nbits,
  output logic             o_sclk,
  output logic             o_cs_n,
  output logic             o_sample,
  output logic             o_shift,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W:0] EDGE_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic [CNT_W:0]   edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             run;
  logic             tick;
  logic [DIV_W-1:0] tick_div;
  logic             lead_edge;
  logic             last_edge;

  assign run = (state_q != ST_IDLE);

  // The timebase preloads while idle, so hand it the divider that is about
  // to be latched rather than the stale latched copy.
  assign tick_div = run ? div_q : i_divider;

  spi_half_period_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_run  (run),
    .i_div  (tick_div),
    .o_tick (tick)
  );

  // edge_q counts edges already issued, so the next edge is leading (odd)
  // when the count is even. The final edge 2N is issued when the count is
  // 2N-1 = {nbits, 1}, which keeps the counter within CNT_W+1 bits.
  assign lead_edge = ~edge_q[0];
  assign last_edge = (edge_q == {nbits_q, 1'b1});

  always_comb begin
    state_d  = state_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    div_d    = div_q;
    nbits_d  = nbits_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    done_d   = 1'b0;

    if (state_q == ST_IDLE) begin
      sclk_d = i_cpol;
      cs_n_d = 1'b1;
      busy_d = 1'b0;
      if (i_enable && i_start) begin
        state_d = ST_LEAD;
        cpol_d  = i_cpol;
        cpha_d  = i_cpha;
        div_d   = i_divider;
        nbits_d = i_nbits;
        edge_d  = '0;
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (!i_enable) begin
      state_d = ST_IDLE;
      sclk_d  = cpol_q;
      cs_n_d  = 1'b1;
      busy_d  = 1'b0;
    end else if (tick) begin
      case (state_q)
        // The tick that ends the lead guard also produces edge 1.
        ST_LEAD, ST_RUN: begin
          sclk_d  = ~sclk_q;
          edge_d  = edge_q + EDGE_ONE;
          state_d = last_edge ? ST_LAG : ST_RUN;
          if (cpha_q == CPHA_TRAILING) begin
            shift_d  = lead_edge;
            sample_d = ~lead_edge;
          end else begin
            sample_d = lead_edge;
            shift_d  = ~lead_edge && ~last_edge;
          end
        end
        ST_LAG: begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cpol_q   <= CPOL_IDLE_LOW;
      cpha_q   <= CPHA_LEADING;
      div_q    <= '0;
      nbits_q  <= '0;
      edge_q   <= '0;
      sclk_q   <= CPOL_IDLE_LOW;
      cs_n_q   <= 1'b1;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_sclk   = sclk_q;
  assign o_cs_n   = cs_n_q;
  assign o_sample = sample_q;
  assign o_shift  = shift_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule
